// File: rtl/jtag_bus_pkg.sv
// Shared encodings for the JTAG bus sequencer: opcodes, command field offsets
// and status bit positions. Host-side Tcl scripts mirror these values.
package jtag_bus_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_NOP     = 3'd0;
    localparam logic [OP_W-1:0] OP_SETADDR = 3'd1;
    localparam logic [OP_W-1:0] OP_WRITE   = 3'd2;
    localparam logic [OP_W-1:0] OP_READ    = 3'd3;
    localparam logic [OP_W-1:0] OP_CLRSTAT = 3'd4;

    // Command word layout, as offsets above the DATA_W-bit payload.
    localparam int CMD_AUTOINC_OFS = 0;
    localparam int CMD_OP_OFS      = 1;

    // Status word layout, as offsets above the DATA_W-bit rdata field.
    localparam int ST_RVALID  = 0;
    localparam int ST_OVERRUN = 1;
    localparam int ST_TIMEOUT = 2;
    localparam int ST_BUSY    = 3;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } seq_state_t;

    function automatic logic is_bus_op(input logic [OP_W-1:0] op);
        return (op == OP_WRITE) || (op == OP_READ);
    endfunction

endpackage

// File: rtl/bus_timeout_counter.sv
// Counts consecutive un-acknowledged request cycles; expired flags the
// TIMEOUT-th such cycle so the sequencer can abandon the transaction.
module bus_timeout_counter #(
    parameter int TIMEOUT = 1023
) (
    input  logic sysclk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    logic [CNT_W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge sysclk) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign expired = enable && (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/jtag_bus_sequencer.sv
// Decodes JTAG USER-register commands into single-beat bus transactions with
// timeout, and reports status and read data on a parallel word for shift-out.
module jtag_bus_sequencer
    import jtag_bus_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int TIMEOUT   = 1023,
    parameter int ADDR_STEP = 4
) (
    input  logic              sysclk,
    input  logic              reset_n,
    input  logic [DATA_W+3:0] cmd_q,
    input  logic              cmd_stb,
    output logic [DATA_W+3:0] resp_d,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ack
);

    logic [OP_W-1:0]   cmd_op;
    logic              cmd_autoinc;
    logic [DATA_W-1:0] cmd_payload;

    assign cmd_op      = cmd_q[DATA_W+CMD_OP_OFS +: OP_W];
    assign cmd_autoinc = cmd_q[DATA_W+CMD_AUTOINC_OFS];
    assign cmd_payload = cmd_q[DATA_W-1:0];

    seq_state_t        state,     state_nxt;
    logic [ADDR_W-1:0] addr_reg,  addr_reg_nxt;
    logic              req_r,     req_nxt;
    logic              we_r,      we_nxt;
    logic [ADDR_W-1:0] baddr_r,   baddr_nxt;
    logic [DATA_W-1:0] wdata_r,   wdata_nxt;
    logic              autoinc_r, autoinc_nxt;
    logic [DATA_W-1:0] rdata_r,   rdata_nxt;
    logic              rvalid_r,  rvalid_nxt;
    logic              timeout_r, timeout_nxt;
    logic              overrun_r, overrun_nxt;

    logic tmr_clear;
    logic tmr_enable;
    logic tmr_expired;

    assign tmr_enable = (state == S_BUSY) && !bus_ack;

    bus_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .sysclk  (sysclk),
        .reset_n (reset_n),
        .clear   (tmr_clear),
        .enable  (tmr_enable),
        .expired (tmr_expired)
    );

    // NOTE: every combinational output gets a default first so no path
    // through the case statements can infer a latch.
    always_comb begin
        state_nxt    = state;
        addr_reg_nxt = addr_reg;
        req_nxt      = req_r;
        we_nxt       = we_r;
        baddr_nxt    = baddr_r;
        wdata_nxt    = wdata_r;
        autoinc_nxt  = autoinc_r;
        rdata_nxt    = rdata_r;
        rvalid_nxt   = rvalid_r;
        timeout_nxt  = timeout_r;
        overrun_nxt  = overrun_r;
        tmr_clear    = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (cmd_stb) begin
                    if (is_bus_op(cmd_op)) begin
                        state_nxt   = S_BUSY;
                        req_nxt     = 1'b1;
                        we_nxt      = (cmd_op == OP_WRITE);
                        baddr_nxt   = addr_reg;
                        wdata_nxt   = cmd_payload;
                        autoinc_nxt = cmd_autoinc;
                        tmr_clear   = 1'b1;
                        if (cmd_op == OP_READ) begin
                            rvalid_nxt = 1'b0;
                        end
                    end else if (cmd_op == OP_SETADDR) begin
                        addr_reg_nxt = ADDR_W'(cmd_payload);
                    end else if (cmd_op == OP_CLRSTAT) begin
                        timeout_nxt = 1'b0;
                        overrun_nxt = 1'b0;
                        rvalid_nxt  = 1'b0;
                    end
                end
            end

            S_BUSY: begin
                // Commands cannot be queued; a strobe here is lost and flagged.
                if (cmd_stb) begin
                    overrun_nxt = 1'b1;
                end
                if (bus_ack) begin
                    state_nxt = S_IDLE;
                    req_nxt   = 1'b0;
                    if (!we_r) begin
                        rdata_nxt  = bus_rdata;
                        rvalid_nxt = 1'b1;
                    end
                    if (autoinc_r) begin
                        addr_reg_nxt = addr_reg + ADDR_W'(ADDR_STEP);
                    end
                end else if (tmr_expired) begin
                    state_nxt   = S_IDLE;
                    req_nxt     = 1'b0;
                    timeout_nxt = 1'b1;
                end
            end

            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            addr_reg  <= '0;
            req_r     <= 1'b0;
            we_r      <= 1'b0;
            baddr_r   <= '0;
            wdata_r   <= '0;
            autoinc_r <= 1'b0;
            rdata_r   <= '0;
            rvalid_r  <= 1'b0;
            timeout_r <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            state     <= state_nxt;
            addr_reg  <= addr_reg_nxt;
            req_r     <= req_nxt;
            we_r      <= we_nxt;
            baddr_r   <= baddr_nxt;
            wdata_r   <= wdata_nxt;
            autoinc_r <= autoinc_nxt;
            rdata_r   <= rdata_nxt;
            rvalid_r  <= rvalid_nxt;
            timeout_r <= timeout_nxt;
            overrun_r <= overrun_nxt;
        end
    end

    assign bus_req   = req_r;
    assign bus_we    = we_r;
    assign bus_addr  = baddr_r;
    assign bus_wdata = wdata_r;

    always_comb begin
        resp_d                     = '0;
        resp_d[DATA_W-1:0]         = rdata_r;
        resp_d[DATA_W+ST_RVALID]   = rvalid_r;
        resp_d[DATA_W+ST_OVERRUN]  = overrun_r;
        resp_d[DATA_W+ST_TIMEOUT]  = timeout_r;
        resp_d[DATA_W+ST_BUSY]     = (state == S_BUSY);
    end

endmodule
